// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 16 {a,b,c,d} vectors through a 4-input combinational block,
// samples y after SETTLE extra cycles per vector and checks the captured table against EXPECTED.
// Ports: clk, rst_n (async active-low), start (sweep request), dut_y (y of the block under test),
// a/b/c/d (stimulus = vector index, a is MSB), busy, done (1-cycle pulse), pass,
// table_q (captured table), mismatch_cnt, first_fail (lowest mismatching index).
module truth_table_sweeper #(
  parameter int SETTLE = 2,
  parameter logic [15:0] EXPECTED = 16'h990F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_q,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, cnt_q, cnt_d, ff_q, ff_d;
  logic [4:0] mm_q, mm_d, mm_n;
  logic [15:0] table_d;
  logic done_q, done_d, pass_q, pass_d, sample, miss;
  always_comb begin
    sample = state_q == DRIVE && cnt_q == 4'(SETTLE);
    miss = dut_y != EXPECTED[idx_q];
    mm_n = mm_q + 5'(miss);
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ff_d = ff_q;
    mm_d = mm_q;
    table_d = table_q;
    done_d = 1'b0;
    pass_d = pass_q;
    if (start && state_q != DRIVE) begin
      state_d = DRIVE;
      idx_d = '0;
      cnt_d = '0;
      ff_d = '0;
      mm_d = '0;
      table_d = '0;
      pass_d = 1'b0;
    end else if (state_q == DRIVE) begin
      cnt_d = sample ? '0 : cnt_q + 4'd1;
      if (sample) begin
        table_d[idx_q] = dut_y;
        mm_d = mm_n;
        ff_d = (miss && mm_q == 0) ? idx_q : ff_q;
        if (idx_q == 4'hF) begin
          state_d = DONE;
          done_d = 1'b1;
          pass_d = mm_n == 0;
        end else idx_d = idx_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      ff_q <= '0;
      mm_q <= '0;
      table_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ff_q <= ff_d;
      mm_q <= mm_d;
      table_q <= table_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign {a, b, c, d} = idx_q;
  assign busy = state_q == DRIVE;
  assign done = done_q;
  assign pass = pass_q;
  assign mismatch_cnt = mm_q;
  assign first_fail = ff_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for truth_table_sweeper at SETTLE=2 and SETTLE=0.
module tb_truth_table_sweeper;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0;
  int mode = 0, cyc = 0, checks = 0, fails = 0;
  logic a0, b0, c0, d0, y0, busy0, done0, pass0, a1, b1, c1, d1, y1, busy1, done1, pass1;
  logic [15:0] t0, t1;
  logic [4:0] m0, m1;
  logic [3:0] f0, f1;
  typedef struct {logic [15:0] t; logic [4:0] m; logic [3:0] f; logic p; int e;} exp_t;
  exp_t q0[$], q1[$];

  function automatic logic model(logic [3:0] v);
    return v[3] ? ~(v[1] ^ v[0]) : ~v[2];
  endfunction

  assign y0 = mode == 1 ? 1'b0 : mode == 2 ? ~model({a0, b0, c0, d0}) : model({a0, b0, c0, d0});
  assign y1 = model({a1, b1, c1, d1});

  truth_table_sweeper #(.SETTLE(2), .EXPECTED(16'h990F)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0), .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .pass(pass0), .table_q(t0), .mismatch_cnt(m0), .first_fail(f0));
  truth_table_sweeper #(.SETTLE(0), .EXPECTED(16'h990F)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y1), .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1), .table_q(t1), .mismatch_cnt(m1), .first_fail(f1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic exp_t expect_for(int md, int e);
    exp_t x;
    x.e = e;
    x.f = 4'd0;
    case (md)
      1: begin x.t = 16'h0000; x.m = 5'd8; x.p = 1'b0; end
      2: begin x.t = 16'h66F0; x.m = 5'd16; x.p = 1'b0; end
      default: begin x.t = 16'h990F; x.m = 5'd0; x.p = 1'b1; end
    endcase
    return x;
  endfunction

  always @(negedge clk) if (done0) begin
    exp_t x;
    if (q0.size() == 0) chk("u0_unexpected_done", 32'(q0.size()), 1);
    else begin
      x = q0.pop_front();
      chk("u0_table", 32'(t0), 32'(x.t));
      chk("u0_mismatch_cnt", 32'(m0), 32'(x.m));
      chk("u0_first_fail", 32'(f0), 32'(x.f));
      chk("u0_pass", 32'(pass0), 32'(x.p));
      chk("u0_done_edge", cyc, x.e);
    end
  end

  always @(negedge clk) if (done1) begin
    exp_t x;
    if (q1.size() == 0) chk("u1_unexpected_done", 32'(q1.size()), 1);
    else begin
      x = q1.pop_front();
      chk("u1_table", 32'(t1), 32'(x.t));
      chk("u1_pass", 32'(pass1), 32'(x.p));
      chk("u1_done_edge", cyc, x.e);
    end
  end

  task automatic sweep0(int md);
    @(negedge clk);
    mode = md;
    start0 = 1;
    q0.push_back(expect_for(md, cyc + 1 + 48));
    @(negedge clk);
    start0 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    chk("drain_timeout", 32'(q0.size() + q1.size()), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {a0, b0, c0, d0, busy0, done0, pass0, t0, m0, f0}, 0);
    rst_n = 1;
    sweep0(0);
    for (int k = 0; k < 48; k++) begin
      chk("order", 32'({busy0, a0, b0, c0, d0}), 32'({1'b1, 4'(k / 3)}));
      @(negedge clk);
    end
    chk("after_done_abcd_busy", 32'({busy0, a0, b0, c0, d0}), 32'h0F);
    drain();
    sweep0(1);
    drain();
    sweep0(2);
    drain();
    sweep0(0);
    repeat (9) @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    drain();
    sweep0(2);
    for (int i = 0; i < 100 && !done0; i++) @(negedge clk);
    start0 = 1;
    mode = 0;
    q0.push_back(expect_for(0, cyc + 1 + 48));
    @(negedge clk);
    start0 = 0;
    chk("restart_in_done_clears", 32'({busy0, pass0, t0, m0}), 32'({1'b1, 1'b0, 16'h0, 5'd0}));
    drain();
    sweep0(0);
    repeat (19) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("async_reset_abort", {a0, b0, c0, d0, busy0, done0, pass0, t0, m0, f0}, 0);
    q0.delete();
    @(negedge clk);
    rst_n = 1;
    sweep0(0);
    drain();
    @(negedge clk);
    start1 = 1;
    q1.push_back(expect_for(0, cyc + 1 + 16));
    @(negedge clk);
    start1 = 0;
    drain();
    repeat (3) @(negedge clk);
    chk("results_hold", 32'({busy0, a0, b0, c0, d0, t0}), 32'({5'h0F, 16'h990F}));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
